cache_refill_seq: RTL and testbench

Line-refill sequencer for the cache controller. It accepts one miss at a time from the lookup stage and invalidates the victim line. It then issues a single line-aligned burst read downstream and writes the four returned beats into the data array. The requested word is forwarded to the core as soon as its beat lands, and the tag is committed last, so a partially filled line is never visible as valid.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_refill_seq.sv | 146 ++++++++++++++
 tb/tb_cache_refill_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache-controller definitions: line geometry, refill FSM states and
// the address-split helpers also used by the lookup stage.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INDEX_W    = 8;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned LINE_BYTES = WORDS * 4;
  localparam int unsigned WORD_W     = $clog2(WORDS);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INVAL,
    ST_REQ,
    ST_BEATS,
    ST_COMMIT
  } state_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+3:4];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W+4];
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
    return addr[WORD_W+1:2];
  endfunction

endpackage

// File: rtl/cache_refill_seq.sv
// Line-refill sequencer: invalidate victim, burst-read the line, write beats
// into the data array, forward the critical word, then commit the tag.
module cache_refill_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned INDEX_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        miss_valid,
  output logic                        miss_ready,
  input  logic [ADDR_W-1:0]           miss_addr,
  output logic                        dn_req_valid,
  input  logic                        dn_req_ready,
  output logic [ADDR_W-1:0]           dn_req_addr,
  input  logic                        dn_beat_valid,
  input  logic [DATA_W-1:0]           dn_beat_data,
  input  logic                        dn_beat_err,
  output logic                        arr_we,
  output logic [INDEX_W-1:0]          arr_index,
  output logic [$clog2(WORDS)-1:0]    arr_word,
  output logic [DATA_W-1:0]           arr_wdata,
  output logic                        tag_we,
  output logic [ADDR_W-INDEX_W-5:0]   tag_value,
  output logic [WORDS-1:0]            tag_valid_mask,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_err,
  output logic                        busy
);
  import cache_pkg::*;

  localparam int unsigned WW = $clog2(WORDS);
  localparam int unsigned TW = ADDR_W - INDEX_W - 4;

  state_t state_q, state_d;

  logic [TW-1:0]      tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [WW-1:0]      crit_q;
  logic [WW-1:0]      cnt_q;
  logic               err_q;

  logic               wr_valid_q;
  logic [WW-1:0]      wr_word_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic               resp_valid_q;
  logic               resp_err_q;
  logic [DATA_W-1:0]  resp_data_q;

  logic beat_fire, last_beat, crit_hit, beat_err;
  logic addr_unused;

  // Byte-offset bits never matter to a line refill.
  assign addr_unused = ^miss_addr[1:0];

  assign beat_fire = (state_q == ST_BEATS) && dn_beat_valid;
  assign last_beat = beat_fire && (cnt_q == WW'(WORDS - 1));
  assign crit_hit  = beat_fire && (cnt_q == crit_q);
  assign beat_err  = err_q | dn_beat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    miss_ready     = 1'b0;
    tag_we         = 1'b0;
    tag_valid_mask = '0;
    dn_req_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_d = ST_INVAL;
      end
      ST_INVAL: begin
        tag_we  = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        dn_req_valid = 1'b1;
        if (dn_req_ready) state_d = ST_BEATS;
      end
      ST_BEATS: begin
        if (last_beat) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        tag_we         = 1'b1;
        tag_valid_mask = err_q ? '0 : '1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= '0;
      index_q      <= '0;
      crit_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_word_q    <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if ((state_q == ST_IDLE) && miss_valid) begin
        tag_q   <= miss_addr[ADDR_W-1:INDEX_W+4];
        index_q <= miss_addr[INDEX_W+3:4];
        crit_q  <= miss_addr[WW+1:2];
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      // Beats land in a one-entry write register; the array write follows a cycle later.
      wr_valid_q <= beat_fire;
      if (beat_fire) begin
        wr_word_q <= cnt_q;
        wr_data_q <= dn_beat_data;
        cnt_q     <= cnt_q + 1'b1;
        err_q     <= beat_err;
      end
      resp_valid_q <= crit_hit;
      resp_err_q   <= crit_hit && beat_err;
      if (crit_hit) resp_data_q <= dn_beat_data;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign dn_req_addr = {tag_q, index_q, 4'b0000};
  assign arr_we      = wr_valid_q;
  assign arr_index   = index_q;
  assign arr_word    = wr_word_q;
  assign arr_wdata   = wr_data_q;
  assign tag_value   = tag_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_cache_refill_seq.sv
// Directed bench for cache_refill_seq: table-driven refills plus hand-written
// back-pressure, back-to-back miss and mid-fill reset sequences.
module tb_cache_refill_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_addr;
  logic        dn_req_valid;
  logic        dn_req_ready;
  logic [31:0] dn_req_addr;
  logic        dn_beat_valid;
  logic [31:0] dn_beat_data;
  logic        dn_beat_err;
  logic        arr_we;
  logic [7:0]  arr_index;
  logic [1:0]  arr_word;
  logic [31:0] arr_wdata;
  logic        tag_we;
  logic [19:0] tag_value;
  logic [3:0]  tag_valid_mask;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  cache_refill_seq #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .INDEX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_addr(dn_req_addr),
    .dn_beat_valid(dn_beat_valid), .dn_beat_data(dn_beat_data), .dn_beat_err(dn_beat_err),
    .arr_we(arr_we), .arr_index(arr_index), .arr_word(arr_word), .arr_wdata(arr_wdata),
    .tag_we(tag_we), .tag_value(tag_value), .tag_valid_mask(tag_valid_mask),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Event log filled on every sampled cycle
  int unsigned wr_cnt, tag_cnt, resp_cnt, resp_cyc;
  logic [31:0] wr_data [4];
  logic [7:0]  wr_index;
  logic [3:0]  tag_first_mask, tag_last_mask;
  logic [19:0] tag_first_val, tag_last_val;
  logic [31:0] resp_d;
  logic        resp_e;
  int unsigned beat_cyc [4];
  int unsigned ready_cyc;

  const logic [31:0] beats [4] = '{32'hFF0000FF, 32'hF0F0F0F0, 32'h00FFFF00, 32'h00FF00FF};

  task automatic clear_log();
    wr_cnt = 0; tag_cnt = 0; resp_cnt = 0; resp_cyc = 0;
    for (int i = 0; i < 4; i++) wr_data[i] = '0;
    wr_index = '0; tag_first_mask = 'x; tag_last_mask = 'x;
    tag_first_val = 'x; tag_last_val = 'x; resp_d = '0; resp_e = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (arr_we) begin
      wr_cnt++;
      wr_data[arr_word] = arr_wdata;
      wr_index = arr_index;
    end
    if (tag_we) begin
      if (tag_cnt == 0) begin
        tag_first_mask = tag_valid_mask;
        tag_first_val  = tag_value;
      end
      tag_last_mask = tag_valid_mask;
      tag_last_val  = tag_value;
      tag_cnt++;
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_d   = resp_data;
      resp_e   = resp_err;
      resp_cyc = cyc;
    end
  endtask

  task automatic wait_ready(input string name);
    int unsigned n;
    n = 0;
    while (!miss_ready && n < 60) begin
      tick();
      n++;
    end
    if (!miss_ready) check({name, " miss_ready timeout"}, 64'(miss_ready), 64'd1);
    ready_cyc = cyc;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  errm;
    int          req_wait;
    int          gap;
    bit          stray;
    logic [1:0]  exp_word;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_index;
    logic [19:0] exp_tag;
  } vec_t;

  task automatic run_fill(input vec_t v, input bit hold_next, input logic [31:0] next_addr);
    logic [31:0] req_a;
    clear_log();
    wait_ready("pre-miss");
    miss_valid = 1'b1;
    miss_addr  = v.addr;
    tick();
    miss_valid = 1'b0;
    tick();
    check("req_valid at T+2", 64'(dn_req_valid), 64'd1);
    check("req_addr aligned", 64'(dn_req_addr), 64'({v.addr[31:4], 4'h0}));
    req_a = dn_req_addr;
    for (int w = 0; w < v.req_wait; w++) begin
      if (v.stray && w == 0) begin
        dn_beat_valid = 1'b1;
        dn_beat_data  = 32'hDEADBEEF;
      end
      tick();
      dn_beat_valid = 1'b0;
      check("req held while not ready", 64'({dn_req_valid, dn_req_addr}), 64'({1'b1, req_a}));
    end
    dn_req_ready = 1'b1;
    tick();
    dn_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dn_beat_valid = 1'b1;
      dn_beat_data  = beats[k];
      dn_beat_err   = v.errm[k];
      beat_cyc[k]   = cyc;
      tick();
      dn_beat_valid = 1'b0;
      dn_beat_err   = 1'b0;
      if (hold_next && k == 0) begin
        miss_valid = 1'b1;
        miss_addr  = next_addr;
      end
      if (hold_next) check("miss_ready low while busy", 64'(miss_ready), 64'd0);
      if (k < 3) for (int g = 0; g < v.gap; g++) tick();
    end
    wait_ready("post-fill");
  endtask

  task automatic check_fill(input vec_t v);
    check("arr write count", 64'(wr_cnt), 64'd4);
    check("arr words 0-1", {wr_data[0], wr_data[1]}, {beats[0], beats[1]});
    check("arr words 2-3", {wr_data[2], wr_data[3]}, {beats[2], beats[3]});
    check("arr_index", 64'(wr_index), 64'(v.exp_index));
    check("resp pulse count", 64'(resp_cnt), 64'd1);
    check("resp_data", 64'(resp_d), 64'(v.exp_data));
    check("resp_err", 64'(resp_e), 64'(v.exp_err));
    check("resp one cycle after critical beat", 64'(resp_cyc), 64'(beat_cyc[v.exp_word] + 1));
    check("tag write count", 64'(tag_cnt), 64'd2);
    check("inval mask", 64'(tag_first_mask), 64'h0);
    check("commit mask", 64'(tag_last_mask), 64'(v.exp_mask));
    check("tag values", 64'({tag_first_val, tag_last_val}), 64'({v.exp_tag, v.exp_tag}));
    check("miss_ready at B3+2", 64'(ready_cyc), 64'(beat_cyc[3] + 2));
  endtask

  vec_t vecs [4];

  initial begin
    rst_n = 1'b0;
    miss_valid = 1'b0; miss_addr = '0;
    dn_req_ready = 1'b0; dn_beat_valid = 1'b0; dn_beat_data = '0; dn_beat_err = 1'b0;
    clear_log();

    vecs[0] = '{32'h011001F0, 4'b0000, 0, 0, 1'b0, 2'd0, 32'hFF0000FF, 1'b0, 4'hF, 8'h1F, 20'h01100};
    vecs[1] = '{32'h0AA001F8, 4'b0000, 0, 0, 1'b0, 2'd2, 32'h00FFFF00, 1'b0, 4'hF, 8'h1F, 20'h0AA00};
    vecs[2] = '{32'h12345ACC, 4'b0010, 0, 0, 1'b0, 2'd3, 32'h00FF00FF, 1'b1, 4'h0, 8'hAC, 20'h12345};
    vecs[3] = '{32'h7FFFFFF4, 4'b0000, 5, 2, 1'b1, 2'd1, 32'hF0F0F0F0, 1'b0, 4'hF, 8'hFF, 20'h7FFFF};

    #1;
    check("reset miss_ready", 64'(miss_ready), 64'd1);
    check("reset quiet outputs",
          64'({busy, dn_req_valid, arr_we, tag_we, resp_valid, resp_err, tag_valid_mask}), 64'h0);
    check("reset data outputs", {dn_req_addr, arr_wdata}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_fill(vecs[i], 1'b0, 32'h0);
      check_fill(vecs[i]);
    end

    // Second miss raised during BEATS must wait for IDLE, then run fully
    run_fill(vecs[0], 1'b1, vecs[1].addr);
    check_fill(vecs[0]);
    check("held miss still asserted", 64'(miss_valid), 64'd1);
    run_fill(vecs[1], 1'b0, 32'h0);
    check_fill(vecs[1]);

    // Reset after beat 1: no commit, line stays invalid
    clear_log();
    wait_ready("reset-seq");
    miss_valid = 1'b1; miss_addr = 32'h011001F0;
    tick();
    miss_valid = 1'b0;
    tick();
    dn_req_ready = 1'b1;
    tick();
    dn_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dn_beat_valid = 1'b1; dn_beat_data = beats[k];
      tick();
      dn_beat_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid-fill reset miss_ready", 64'(miss_ready), 64'd1);
    check("mid-fill reset quiet",
          64'({busy, dn_req_valid, arr_we, tag_we, resp_valid, tag_valid_mask}), 64'h0);
    check("mid-fill reset data", {dn_req_addr, arr_wdata}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid-fill writes before reset", 64'(wr_cnt), 64'd2);
    check("no commit after reset", 64'(tag_cnt), 64'd1);
    check("last tag write invalid", 64'(tag_last_mask), 64'h0);
    check("idle after reset", 64'({busy, miss_ready}), 64'b01);

    run_fill(vecs[2], 1'b0, 32'h0);
    check_fill(vecs[2]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
